// File: rtl/uart_pkg.sv
// Shared types and constants for the counter-observation UART transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;
  localparam int UART_IDX_W                = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: tick is high on the last cycle of every CLKS_PER_BIT period.
// No pipeline latency; restart holds the count at zero; no backpressure.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("baud_tick_gen: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

  // Wrapping on tick restarts the count at every bit boundary, so periods never drift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// 8N1 UART transmitter for the free-running counter; start bit begins 1 cycle after acceptance.
// Accepts one byte per valid/ready handshake in IDLE only; valid outside IDLE is ignored.
module count_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       txd,
  output logic       busy
);

  uart_tx_state_t            state;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_IDX_W-1:0]     bit_idx;
  logic                      baud_restart;
  logic                      tick;

  assign baud_restart = (state == IDLE);
  assign busy         = ~data_ready;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(baud_restart),
    .tick   (tick)
  );

  // txd is loaded with the value of the upcoming bit on each transition, keeping it a clean flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      txd        <= 1'b1;
      data_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid && data_ready) begin
            shift_reg  <= data;
            bit_idx    <= '0;
            txd        <= 1'b0;
            data_ready <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (tick) begin
            txd   <= shift_reg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
            if (bit_idx == UART_IDX_W'(UART_DATA_BITS - 1)) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd     <= shift_reg[1];
              bit_idx <= bit_idx + UART_IDX_W'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            data_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx at CLKS_PER_BIT=4: accepted bytes go to a scoreboard that a
// line receiver drains, checking bit timing, stop bit and start latency per frame.
module tb_count_uart_tx;

  localparam int C     = 4;
  localparam int FRAME = 10 * C;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic [7:0] data       = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       txd;
  logic       busy;

  count_uart_tx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .txd       (txd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int edge_n    = 0;
  int acc_cnt   = 0;
  int rx_frames = 0;
  int rx_gap    = -1;

  logic [7:0] exp_q[$];
  int         acc_q[$];

  int         lo, bad, hi, f0, a0;
  logic [7:0] cnt8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int a;
    a          = acc_cnt;
    data       = b;
    data_valid = 1'b1;
    for (int i = 0; i < 100 && acc_cnt == a; i++) @(negedge clk);
    data_valid = 1'b0;
    check("send_accepted", acc_cnt, a + 1);
  endtask

  task automatic wait_frames(input int target, input string tag);
    for (int i = 0; i < 200 && rx_frames < target; i++) @(negedge clk);
    check(tag, rx_frames, target);
  endtask

  // Handshake monitor: edge_n numbers rising edges; each acceptance records byte and edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && data_valid && data_ready) begin
        exp_q.push_back(data);
        acc_q.push_back(edge_n);
        acc_cnt++;
      end
      edge_n++;
    end
  end

  // Line receiver; at a falling edge, edge_n is the index of the current cycle.
  initial begin : rx
    int         pos;
    int         start;
    int         last_data_end;
    int         acc;
    logic       active;
    logic       stable;
    logic [9:0] bits;
    logic [7:0] got_b;
    logic [7:0] exp_b;
    pos           = 0;
    start         = 0;
    last_data_end = -1000;
    active        = 1'b0;
    stable        = 1'b1;
    bits          = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        exp_q.delete();
        acc_q.delete();
        last_data_end = -1000;
      end else begin
        if (!active && txd === 1'b0) begin
          active = 1'b1;
          pos    = 0;
          start  = edge_n;
          stable = 1'b1;
        end
        if (active) begin
          if (pos % C == 0) bits[pos/C] = txd;
          else if (txd !== bits[pos/C]) stable = 1'b0;
          pos++;
          if (pos == FRAME) begin
            active = 1'b0;
            for (int i = 0; i < 8; i++) got_b[i] = bits[i+1];
            check("rx_stop_bit", bits[9], 1);
            check("rx_bit_stable", stable, 1);
            check("rx_frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              exp_b = exp_q.pop_front();
              acc   = acc_q.pop_front();
              check("rx_data", got_b, exp_b);
              check("rx_start_latency", start - acc, 1);
            end
            rx_gap        = start - last_data_end - 1;
            last_data_end = start + 9 * C - 1;
            rx_frames++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_txd", txd, 1);
      check("rst_ready", data_ready, 1);
      check("rst_busy", busy, 0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_txd", txd, 1);
      check("post_rst_ready", data_ready, 1);
      check("post_rst_busy", busy, 0);
    end

    // Single byte 0xA5.
    f0 = rx_frames;
    send(8'hA5);
    lo  = 0;
    bad = 0;
    for (int i = 0; i < 100 && !data_ready; i++) begin
      lo++;
      if (busy !== ~data_ready) bad++;
      @(negedge clk);
    end
    check("single_ready_low_cycles", lo, FRAME);
    check("single_busy_inverse", bad, 0);
    wait_frames(f0 + 1, "single_frame");

    // Back-to-back with data_valid held high.
    f0 = rx_frames;
    a0 = acc_cnt;
    data       = 8'h00;
    data_valid = 1'b1;
    hi = 0;
    for (int i = 0; i < 200 && acc_cnt < a0 + 2; i++) begin
      @(negedge clk);
      if (acc_cnt == a0 + 1) begin
        data = 8'hFF;
        if (data_ready) hi++;
      end
    end
    data_valid = 1'b0;
    check("b2b_accepts", acc_cnt, a0 + 2);
    check("b2b_ready_high_cycles", hi, 1);
    wait_frames(f0 + 2, "b2b_frames");
    check("b2b_line_high_cycles", rx_gap, C + 1);

    // Latched data is immune to later changes and mid-frame valid.
    f0 = rx_frames;
    a0 = acc_cnt;
    send(8'h3C);
    data = 8'hC3;
    repeat (15) @(negedge clk);
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_frames(f0 + 1, "stab_frame");
    repeat (60) @(negedge clk);
    check("stab_no_second_accept", acc_cnt, a0 + 1);
    check("stab_frame_count", rx_frames, f0 + 1);

    // Reset during data bit 3 of 0x00.
    f0 = rx_frames;
    send(8'h00);
    repeat (17) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    check("midrst_txd_before", txd, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ready", data_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_frame", rx_frames, f0);
    send(8'h81);
    wait_frames(f0 + 1, "post_midrst_frame");

    // Free-running counter drives data with valid held high.
    f0 = rx_frames;
    a0 = acc_cnt;
    cnt8 = 8'h37;
    data_valid = 1'b1;
    for (int i = 0; i < 3 * (FRAME + 1) + 5; i++) begin
      data = cnt8;
      cnt8 = cnt8 + 8'd1;
      @(negedge clk);
    end
    data_valid = 1'b0;
    check("cnt_accepts", acc_cnt - a0, 4);
    wait_frames(f0 + 4, "cnt_frames");

    repeat (5) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_uart_tx.md
# count_uart_tx

Serial transmitter stage directly downstream of the 8-bit free-running counter. It accepts one byte per valid/ready handshake, latches it, and shifts it out on a single UART line as 8N1: one start bit, eight data bits LSB first, one stop bit. In the board top level, `data` connects to the counter's `count` output, and `txd` drives the FPGA's UART TX pin so counter values can be observed on a host terminal.

## Interface
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200 baud): clock cycles per serial bit. Must be ≥ 2; elaboration fails otherwise.
- `clk`  in  1  single system clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `data`  in  8  byte to transmit; sampled only at acceptance.
- `data_valid`  in  1  upstream has a byte.
- `data_ready`  out  1  block can accept a byte (high only in IDLE).
- `txd`  out  1  serial line; idle level is 1.
- `busy`  out  1  a frame is in progress (inverse of `data_ready`).

## Operation
- State machine has four states: IDLE, START, DATA, STOP.
- IDLE: `txd`=1, `data_ready`=1. On `data_valid & data_ready` at a rising edge:
  - latch `data` into the shift register;
  - clear the bit counter;
  - go to START.
- START: `txd`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: `txd` = shift_reg[0]. Each bit lasts `CLKS_PER_BIT` cycles, then shift right. The 3-bit index counts 0..7; after bit 7 go to STOP.
- STOP: `txd`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- `txd` is a registered output, so it never glitches.
- Data latched at acceptance is immune to later changes on `data`.
- `data_valid` outside IDLE is ignored. There is no queue; upstream holds or drops the value.
- The baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0..`CLKS_PER_BIT`-1 and restarts on every state entry, so there is no accumulated drift.
- Reset values (immediate on `rst_n` low, asynchronous):
  - state=IDLE, `txd`=1, `data_ready`=1, `busy`=0;
  - shift register=0, baud counter=0, bit index=0.
- Reset asserted mid-frame aborts the frame. The line returns to 1 at once, and the first frame after reset release starts clean.

## Timing
- Let C = `CLKS_PER_BIT`. Acceptance occurs at rising edge k.
- `data_ready`/`busy` change in the cycle after edge k.
- Start bit occupies cycles k+1 .. k+C.
- Data bit i occupies cycles k+1+(i+1)C .. k+(i+2)C.
- Stop bit occupies cycles k+1+9C .. k+10C.
- Frame length is exactly 10C cycles.
- `data_ready` returns high in cycle k+10C+1.
- With `data_valid` held high, the next start bit begins in cycle k+10C+2. Between frames the line is 1 for C+1 cycles (stop bit plus one IDLE cycle).
- Latency from acceptance to start-bit edge is 1 cycle.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_tx_state_t` (IDLE, START, DATA, STOP);
  - `UART_DATA_BITS` = 8;
  - `UART_DEFAULT_CLKS_PER_BIT` = 434.
- Sub-module `baud_tick_gen` (parameter `CLKS_PER_BIT`):
  - inputs `clk`, `rst_n`, `restart`; output `tick`;
  - `tick` pulses on the last cycle of each bit period;
  - `restart` zeroes the count.
- `count_uart_tx` instantiates one `baud_tick_gen` and owns the state machine, shift register and bit index.

## Test plan
All scenarios use C=4.
- Reset: hold `rst_n`=0 for 3 cycles, then release → `txd`=1, `data_ready`=1, `busy`=0 throughout reset and after release.
- Single byte: pulse `data_valid` one cycle with `data`=0xA5 → `txd` sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `data_ready` is low for exactly 40 cycles.
- Back-to-back: hold `data_valid`=1, presenting 0x00 then 0xFF at the two acceptances → two frames. `data_ready` is high for exactly 1 cycle between them, and the line is 1 for 5 cycles between frames.
- Data stability: accept 0x3C, then toggle `data` to 0xC3 and pulse `data_valid` mid-frame → the frame still carries 0x3C, and no second frame is started.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0x00 → `txd`=1 in the same cycle and `busy`=0. After release, 0x81 transmits correctly.
- Counter integration: connect a free-running 8-bit counter to `data` with `data_valid`=1. A bench UART receiver decodes bytes, and each received byte equals the counter value at its acceptance edge.
